// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and width presets for pipeline stage registers
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_t;

  // Wide enough for any stage; instantiators slice the low CTRL_W bits.
  localparam int MAX_CTRL_W = 64;
  localparam logic [MAX_CTRL_W-1:0] BUBBLE_CTRL = '0;

  // EX/MEM carries ALU result, store data and PC+4; MEM/WB carries memory data and ALU result.
  localparam int EXMEM_DATA_W = 96;
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 64;
  localparam int MEMWB_CTRL_W = 8;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating event counter with async active-low clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional 2-entry skid
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int ENT_W = CTRL_W + DATA_W;
  localparam logic [ENT_W-1:0] EMPTY_WORD = {BUBBLE_CTRL[CTRL_W-1:0], {DATA_W{1'b0}}};

  ps_state_t        state_q, state_d;
  logic [ENT_W-1:0] head_q, head_d;
  logic [ENT_W-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic             in_xfer, out_xfer, bubble_inc;
  logic [ENT_W-1:0] in_word;

  assign in_word = {in_ctrl, in_data};
  assign {out_ctrl, out_data} = head_q;

  // Skid mode: ready comes from a flop so out_ready never reaches in_ready.
  always_comb begin
    out_valid = (state_q != PS_EMPTY) & ~stall & ~flush;
    if (SKID != 0) begin
      in_ready = rst & ready_q & ~stall & ~flush;
    end else begin
      in_ready = rst & ~stall & ~flush & ((state_q == PS_EMPTY) | out_ready);
    end
  end

  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;
  assign bubble_inc = out_ready & ~out_valid & ~stall & ~flush;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      head_d  = EMPTY_WORD;
      skid_d  = EMPTY_WORD;
    end else if (!stall) begin
      case (state_q)
        PS_EMPTY: begin
          if (in_xfer) begin
            head_d  = in_word;
            state_d = PS_ONE;
          end
        end
        PS_ONE: begin
          if (in_xfer && out_xfer) begin
            head_d = in_word;
          end else if (in_xfer && (SKID != 0)) begin
            skid_d  = in_word;
            state_d = PS_TWO;
          end else if (out_xfer) begin
            head_d  = EMPTY_WORD;
            state_d = PS_EMPTY;
          end
        end
        PS_TWO: begin
          if (out_xfer) begin
            head_d  = skid_q;
            skid_d  = EMPTY_WORD;
            state_d = PS_ONE;
          end
        end
        default: begin
          state_d = PS_EMPTY;
          head_d  = EMPTY_WORD;
          skid_d  = EMPTY_WORD;
        end
      endcase
    end
    ready_d = (state_d != PS_TWO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PS_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .clk   (clk),
    .clr_n (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg in skid, single-entry and small-counter builds
module tb_pipe_stage_reg;

  logic        clk, rst, stall, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [15:0] bubble_cnt;

  logic        in_valid_0, in_ready_0, out_valid_0, out_ready_0, stall_0, flush_0;
  logic [31:0] in_data_0, out_data_0;
  logic [7:0]  in_ctrl_0, out_ctrl_0;
  logic [15:0] bubble_cnt_0;

  logic        rst_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c, stall_c, flush_c;
  logic [31:0] in_data_c, out_data_c;
  logic [7:0]  in_ctrl_c, out_ctrl_c;
  logic [1:0]  bubble_cnt_c;

  int n_checks = 0;
  int n_errors = 0;
  int n_out = 0;
  logic [39:0] sb[$];

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .stall(stall_0), .flush(flush_0),
    .in_valid(in_valid_0), .in_ready(in_ready_0), .in_data(in_data_0), .in_ctrl(in_ctrl_0),
    .out_valid(out_valid_0), .out_ready(out_ready_0), .out_data(out_data_0), .out_ctrl(out_ctrl_0),
    .bubble_cnt(bubble_cnt_0)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst_c), .stall(stall_c), .flush(flush_c),
    .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c), .in_ctrl(in_ctrl_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c), .out_ctrl(out_ctrl_c),
    .bubble_cnt(bubble_cnt_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c,
                       input logic ordy, input logic st, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Words are expected when accepted and retired when the stage hands them on.
  always @(negedge clk) begin
    if (!rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        chk("sb_avail", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) chk("sb_data", 64'({out_ctrl, out_data}), 64'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    clk = 0; rst = 0; rst_c = 0;
    drive(0, 0, 0, 0, 0, 0);
    in_valid_0 = 0; in_data_0 = 0; in_ctrl_0 = 0; out_ready_0 = 0; stall_0 = 0; flush_0 = 0;
    in_valid_c = 0; in_data_c = 0; in_ctrl_c = 0; out_ready_c = 1; stall_c = 0; flush_c = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_bub", 64'(bubble_cnt), 64'd0);
    rst = 1;
    #1 chk("rel_ready", 64'(in_ready), 64'd1);

    // streaming: out_ready only while a word is present, so no bubble cycles
    for (int i = 0; i <= 8; i++) begin
      drive(i < 8, 32'h100 + 32'(i), 8'h81, i > 0, 0, 0);
      @(negedge clk);
      if (i < 8) chk("stream_ready", 64'(in_ready), 64'd1);
      if (i > 0) chk("stream_out", 64'({out_ctrl, out_data}), 64'h81_0000_0100 + 64'(i - 1));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("stream_bub", 64'(bubble_cnt), 64'd0);

    // backpressure: three cycles with out_ready low
    drive(1, 32'h200, 8'h42, 0, 0, 0);
    @(negedge clk) chk("bp_ready0", 64'(in_ready), 64'd1);
    tick();
    drive(1, 32'h201, 8'h42, 0, 0, 0);
    @(negedge clk) chk("bp_ready1", 64'(in_ready), 64'd1);
    tick();
    drive(1, 32'h202, 8'h42, 0, 0, 0);
    @(negedge clk) chk("bp_two_ready", 64'(in_ready), 64'd0);
    chk("bp_head", 64'(out_data), 64'h200);
    tick();
    drive(1, 32'h202, 8'h42, 1, 0, 0);
    @(negedge clk) chk("bp_rel_ready", 64'(in_ready), 64'd0);
    tick();
    @(negedge clk) chk("bp_ready_back", 64'(in_ready), 64'd1);
    chk("bp_second", 64'(out_data), 64'h201);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk) chk("bp_third", 64'(out_data), 64'h202);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) chk("bp_empty", 64'(out_valid), 64'd0);
    tick();

    // flush while full, with a competing word on the input
    drive(1, 32'h300, 8'h11, 0, 0, 0);
    tick();
    drive(1, 32'h301, 8'h11, 0, 0, 0);
    tick();
    drive(1, 32'hDEAD, 8'h11, 1, 0, 1);
    @(negedge clk) chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) chk("fl_next_valid", 64'(out_valid), 64'd0);
    chk("fl_ctrl", 64'(out_ctrl), 64'd0);
    chk("fl_data", 64'(out_data), 64'd0);
    chk("fl_ready_back", 64'(in_ready), 64'd1);
    chk("fl_bub", 64'(bubble_cnt), 64'd0);
    tick();

    // stall holding 0x55 while downstream is ready
    drive(1, 32'h55, 8'h81, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h66, 8'h81, 1, 1, 0);
      @(negedge clk) chk("st_ready", 64'(in_ready), 64'd0);
      chk("st_valid", 64'(out_valid), 64'd0);
      chk("st_bub", 64'(bubble_cnt), 64'd0);
      tick();
    end
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk) chk("st_rel_valid", 64'(out_valid), 64'd1);
    chk("st_rel_word", 64'({out_ctrl, out_data}), 64'h81_0000_0055);
    tick();
    @(negedge clk) chk("st_after_valid", 64'(out_valid), 64'd0);
    tick();
    chk("bub_inc", 64'(bubble_cnt), 64'd1);
    drive(0, 0, 0, 0, 0, 0);

    // asynchronous reset while holding a word
    drive(1, 32'h77, 8'h81, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 0;
    #1 chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_word", 64'({out_ctrl, out_data}), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd0);
    chk("ar_bub", 64'(bubble_cnt), 64'd0);
    tick();
    rst = 1;

    // single-entry build: ready follows out_ready combinationally
    in_valid_0 = 1; in_data_0 = 32'hA1; in_ctrl_0 = 8'h81; out_ready_0 = 0;
    #1 chk("s0_empty_ready", 64'(in_ready_0), 64'd1);
    tick();
    in_data_0 = 32'hA2;
    #1 chk("s0_blocked", 64'(in_ready_0), 64'd0);
    out_ready_0 = 1;
    #1 chk("s0_comb_ready", 64'(in_ready_0), 64'd1);
    chk("s0_head", 64'(out_data_0), 64'hA1);
    tick();
    chk("s0_replaced", 64'(out_data_0), 64'hA2);
    chk("s0_valid", 64'(out_valid_0), 64'd1);
    in_valid_0 = 0;
    tick();
    out_ready_0 = 0;

    // small counter against an idle sink
    rst_c = 1;
    repeat (2) tick();
    chk("cnt_two", 64'(bubble_cnt_c), 64'd2);
    repeat (4) tick();
    chk("cnt_sat", 64'(bubble_cnt_c), 64'd3);

    chk("sb_left", 64'(sb.size()), 64'd0);
    chk("delivered", 64'(n_out), 64'd12);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
